// File: rtl/prio_scan_enc.sv
// Sequential priority scanner: latches an N-bit request vector, then emits the
// index of every set bit one per output handshake, in priority order.
// Latency: vector accepted at edge k -> first index valid in cycle k+1, then one
//   index per cycle while out_ready=1; back-to-back reload with no bubble.
// Backpressure: out_ready=0 freezes pending/out_idx/out_last/remain; in_ready is
//   high only when idle or when the last pending bit is being consumed.
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     request vector handshake, in_data = request vector
//   out_valid/out_ready   index handshake, out_idx = current priority index
//   out_last              out_idx is the final pending bit
//   remain                popcount of the pending vector
//   zero_in               one-cycle pulse after an all-zero vector is accepted
//   busy                  pending vector is non-zero
module prio_scan_enc #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDX_W    = $clog2(N),
  localparam int CNT_W    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [CNT_W-1:0] remain,
  output logic             zero_in,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             zero_in_q, zero_in_d;

  logic [IDX_W-1:0] enc_idx;
  logic [CNT_W-1:0] pop_cnt;
  logic [N-1:0]     clr_mask;
  logic             fire_in;
  logic             fire_out;

  // Priority encode and popcount of the pending vector. Iterating in the
  // opposite direction to priority lets the last match win, so no break is
  // needed. An empty vector encodes to 0.
  always_comb begin
    enc_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (pending_q[i]) enc_idx = IDX_W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pending_q[i]) enc_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + {{(CNT_W-1){1'b0}}, pending_q[i]};
    end
  end

  // One-hot mask of the bit being consumed; built by comparison so that a
  // non-power-of-two N never indexes past the vector.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (enc_idx == IDX_W'(i)) clr_mask[i] = 1'b1;
    end
  end

  // Output process
  always_comb begin
    out_valid = (state_q == SCAN);
    busy      = out_valid;
    out_idx   = enc_idx;
    remain    = pop_cnt;
    out_last  = out_valid && (pop_cnt == CNT_W'(1));
    zero_in   = zero_in_q;
    fire_out  = out_valid && out_ready;
    // Accept a new vector while idle, or in the same cycle the last pending
    // bit leaves, so consecutive vectors stream without a bubble.
    in_ready  = (state_q == IDLE) || (out_valid && out_last && out_ready);
    fire_in   = in_valid && in_ready;
  end

  // Next-state process. A load on the last-bit handshake overwrites pending
  // entirely; the bit being consumed is the only one left, so nothing is lost.
  always_comb begin
    pending_d = pending_q;
    if (fire_in) begin
      pending_d = in_data;
    end else if (fire_out) begin
      pending_d = pending_q & ~clr_mask;
    end
    zero_in_d = fire_in && (in_data == '0);
    state_d   = (pending_d != '0) ? SCAN : IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_in_q <= zero_in_d;
    end
  end

endmodule

// File: tb/tb_prio_scan_enc.sv
// Bench for prio_scan_enc: three instances (N=8 MSB-first, N=8 LSB-first,
// N=5 MSB-first) share one stimulus stream; each has its own index-queue model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_prio_scan_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic [2:0] ir, ov, ol, zi, bz;
  logic [2:0] oi0, oi1, oi2;
  logic [3:0] rm0, rm1;
  logic [2:0] rm2;

  int total = 0;
  int bad   = 0;

  prio_scan_enc #(.N(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_idx(oi0), .out_last(ol[0]), .remain(rm0), .zero_in(zi[0]), .busy(bz[0])
  );

  prio_scan_enc #(.N(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_idx(oi1), .out_last(ol[1]), .remain(rm1), .zero_in(zi[1]), .busy(bz[1])
  );

  prio_scan_enc #(.N(5), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data[4:0]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_idx(oi2), .out_last(ol[2]), .remain(rm2), .zero_in(zi[2]), .busy(bz[2])
  );

  // ---------------- reference model: ordered list of indices still owed ----
  int qa[3][8];
  int qn[3];
  bit zp[3];

  function automatic void chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void mload(int k, logic [7:0] d);
    int n;
    n = (k == 2) ? 5 : 8;
    qn[k] = 0;
    if (k == 1) begin
      for (int i = 0; i < n; i++)
        if (d[i]) begin qa[k][qn[k]] = i; qn[k]++; end
    end else begin
      for (int i = n - 1; i >= 0; i--)
        if (d[i]) begin qa[k][qn[k]] = i; qn[k]++; end
    end
    zp[k] = (qn[k] == 0);
  endfunction

  function automatic bit mrdy(int k);
    return (qn[k] == 0) || (qn[k] == 1 && out_ready);
  endfunction

  function automatic void mstep(int k);
    bit fi, fo;
    fi = in_valid && mrdy(k);
    fo = (qn[k] > 0) && out_ready;
    zp[k] = 1'b0;
    if (fo) begin
      for (int i = 0; i < 7; i++) qa[k][i] = qa[k][i+1];
      qn[k]--;
    end
    if (fi) mload(k, in_data);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin qn[k] = 0; zp[k] = 1'b0; end
    end else begin
      for (int k = 0; k < 3; k++) mstep(k);
    end
  end

  function automatic int act_idx(int k);
    return (k == 0) ? int'(oi0) : (k == 1) ? int'(oi1) : int'(oi2);
  endfunction

  function automatic int act_rem(int k);
    return (k == 0) ? int'(rm0) : (k == 1) ? int'(rm1) : int'(rm2);
  endfunction

  // Compare process: every falling edge, all instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(qn[k] > 0));
      chk($sformatf("busy[%0d]", k), int'(bz[k]), int'(qn[k] > 0));
      chk($sformatf("out_idx[%0d]", k), act_idx(k), (qn[k] > 0) ? qa[k][0] : 0);
      chk($sformatf("out_last[%0d]", k), int'(ol[k]), int'(qn[k] == 1));
      chk($sformatf("remain[%0d]", k), act_rem(k), qn[k]);
      chk($sformatf("zero_in[%0d]", k), int'(zi[k]), int'(zp[k]));
      chk($sformatf("in_ready[%0d]", k), int'(ir[k]), int'(mrdy(k)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    int e_msb[4];
    int e_lsb[4];
    int e5[3];
    e_msb = '{7, 5, 2, 0};
    e_lsb = '{0, 2, 5, 7};
    e5    = '{4, 2, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    repeat (2) cyc();
    chk("rst_in_ready", int'(ir[0]), 1);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_out_idx", int'(oi0), 0);
    chk("rst_remain", int'(rm0), 0);
    rst_n = 1'b1;
    repeat (2) cyc();

    // 8'hA5 streamed at full rate, both priority orders
    load(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("a5_idx_msb", int'(oi0), e_msb[i]);
      chk("a5_remain", int'(rm0), 4 - i);
      chk("a5_last_msb", int'(ol[0]), int'(i == 3));
      chk("a5_idx_lsb", int'(oi1), e_lsb[i]);
      chk("a5_last_lsb", int'(ol[1]), int'(i == 3));
    end
    @(negedge clk);
    chk("a5_done_valid", int'(ov[0]), 0);
    chk("a5_done_ready", int'(ir[0]), 1);
    cyc();

    // 8'h81 with three stalled cycles
    out_ready = 1'b0;
    load(8'h81);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_idx", int'(oi0), 7);
      chk("bp_remain", int'(rm0), 2);
      chk("bp_in_ready", int'(ir[0]), 0);
    end
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_idx0", int'(oi0), 7);
    @(negedge clk);
    chk("bp_rel_idx1", int'(oi0), 0);
    chk("bp_rel_last", int'(ol[0]), 1);
    @(negedge clk);
    chk("bp_rel_done", int'(ov[0]), 0);
    cyc();

    // all-zero vector
    load(8'h00);
    @(negedge clk);
    chk("zero_pulse", int'(zi[0]), 1);
    chk("zero_no_valid", int'(ov[0]), 0);
    chk("zero_ready", int'(ir[0]), 1);
    @(negedge clk);
    chk("zero_pulse_end", int'(zi[0]), 0);
    cyc();

    // back-to-back reload on the last-bit handshake
    in_valid = 1'b1;
    in_data  = 8'h10;
    cyc();
    in_data  = 8'h03;
    @(negedge clk);
    chk("b2b_idx_first", int'(oi0), 4);
    chk("b2b_last", int'(ol[0]), 1);
    chk("b2b_in_ready", int'(ir[0]), 1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", int'(ov[0]), 1);
    chk("b2b_idx", int'(oi0), 1);
    chk("b2b_remain", int'(rm0), 2);
    repeat (4) cyc();

    // reset in the middle of a scan
    load(8'hFF);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(ov[0]), 0);
    chk("mid_rst_remain", int'(rm0), 0);
    chk("mid_rst_busy", int'(bz[0]), 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", int'(ov[0]), 0);
    end
    cyc();

    // N=5: 5'b10110
    load(8'h16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("n5_idx", int'(oi2), e5[i]);
      chk("n5_remain", int'(rm2), 3 - i);
    end
    cyc();

    // randomized traffic
    repeat (3000) begin
      cyc();
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      if ($urandom_range(0, 7) == 0) in_data = 8'h00;
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 299) != 0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (10) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio_scan_enc.md
Name: prio_scan_enc

Overview:
- Parametrised, sequential successor to the fixed 8-to-3 priority encoder.
- Accepts an N-bit request vector over a valid/ready handshake, latches it, then emits the index of every set bit one per handshake, in priority order.
- Each bit is cleared from the pending vector as its index is consumed.
- Sits between request-collection logic and any consumer that must service every asserted line, not just the highest one.

Parameters:
- N, 8, request vector width; must be ≥ 2.
- IDX_W, $clog2(N), width of the output index; derived, not overridden.
- CNT_W, $clog2(N+1), width of the remaining-bit count; derived.
- MSB_FIRST, 1, priority order. 1 = highest set index wins (matches the 8x3 encoder). 0 = lowest set index wins.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request vector offered.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  N  request vector.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_idx  output  IDX_W  index of the current highest-priority pending bit.
- out_last  output  1  current index is the final pending bit.
- remain  output  CNT_W  popcount of the pending vector.
- zero_in  output  1  one-cycle pulse: an accepted vector was all zeros.
- busy  output  1  pending vector is non-zero.

Behaviour:
- Reset (async assert, sync release), all registered outputs:
  - state=IDLE, pending=0, zero_in=0.
  - Hence out_valid=0, out_idx=0, out_last=0, remain=0, busy=0, in_ready=1.
- States:
  - IDLE: pending==0.
  - SCAN: pending!=0.
- Outputs derived from state and pending:
  - out_valid = (state==SCAN).
  - busy = out_valid.
  - out_idx = priority encode of pending per MSB_FIRST; 0 when pending==0.
  - out_last = out_valid and popcount(pending)==1.
  - remain = popcount(pending).
- Accept: fire_in = in_valid & in_ready.
  - in_ready = (state==IDLE) | (out_valid & out_last & out_ready).
  - in_ready is combinational on out_ready; no other in→out combinational path.
- Emit: fire_out = out_valid & out_ready.
  - Next cycle, pending has the bit at out_idx cleared.
  - remain decrements by 1.
- Latency:
  - Vector accepted at edge k gives out_valid=1 from cycle k+1.
  - First index is visible with zero further delay.
  - One index per cycle while out_ready=1.
- Back-to-back:
  - If fire_out on the last bit and fire_in occur in the same cycle, pending loads the new in_data directly.
  - No idle bubble. out_valid stays 1 if the new vector is non-zero.
- Zero vector:
  - fire_in with in_data==0 leaves pending=0 and state=IDLE.
  - zero_in=1 for exactly the next cycle; no index is emitted.
  - The same applies to a zero vector accepted back-to-back.
- Backpressure:
  - While out_valid=1 and out_ready=0: pending, out_idx, out_last and remain are held stable.
  - in_ready=0 (unless in IDLE).
- in_valid while in SCAN and not on the last handshake is ignored (not accepted); the upstream must hold it.
- Reset mid-scan:
  - Pending bits are discarded; outputs return to reset values immediately on rst_n falling.
  - No index is emitted after reset release until a new vector is accepted.
- N not a power of two: out_idx never exceeds N-1; unused encodings never appear.

Test Plan:
- N=8, MSB_FIRST=1, load 8'hA5, out_ready=1 → out_idx 7,5,2,0 on four consecutive cycles; remain 4,3,2,1; out_last only with idx 0; then out_valid=0, in_ready=1.
- Same load, MSB_FIRST=0 → out_idx 0,2,5,7; out_last with idx 7.
- Load 8'h81, out_ready low for 3 cycles after first out_valid → out_idx held at 7, remain=2, in_ready=0 throughout; after release, 7 then 0.
- Load 8'h00 → zero_in high one cycle, out_valid never asserts, in_ready stays 1.
- Load 8'h10, then offer 8'h03 during the last-bit handshake → in_ready=1 that cycle; next cycle out_idx=1, remain=2; no bubble.
- Load 8'hFF, pull rst_n low after 2 emitted indices → out_valid, remain, busy go 0 immediately; after release, no index until the next load. Repeat with N=5, load 5'b10110 → indices 4,2,1.
